// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory port of the fetch unit: one outstanding request, ready is a one-cycle strobe.
interface instruction_fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, single-outstanding imem request, stall hold buffer, registered IF/ID and
// branch/JAL/JALR redirect with sticky misaligned-target trap.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     reset,
  instruction_fetch_unit_if.master imem,
  input  logic                     stall_i,
  input  logic                     redirect_i,
  input  logic                     jalr_i,
  input  logic [31:0]              rs1_i,
  input  logic [31:0]              imm_i,
  output logic [31:0]              instr_o,
  output logic [6:0]               op_o,
  output logic [31:0]              id_pc_o,
  output logic [31:0]              id_pc4_o,
  output logic                     id_valid_o,
  output logic                     misaligned_o
);

  typedef enum logic [1:0] {FETCH, HOLD, KILL, TRAP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] kill_addr_q, kill_addr_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_valid_q, id_valid_d;
  logic        mis_q, mis_d;

  logic [31:0] jalr_sum;
  logic [31:0] target;
  logic        take_redirect;
  logic        target_misaligned;

  assign jalr_sum          = rs1_i + imm_i;
  assign target            = jalr_i ? {jalr_sum[31:1], 1'b0} : (id_pc_q + imm_i);
  assign target_misaligned = (target[1:0] != 2'b00);
  assign take_redirect     = redirect_i && id_valid_q && !stall_i;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_addr_d  = kill_addr_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    instr_d      = instr_q;
    id_pc_d      = id_pc_q;
    id_valid_d   = id_valid_q;
    mis_d        = mis_q;

    // An unstalled ID register becomes a bubble unless a word is loaded below.
    if (!stall_i) begin
      instr_d    = NOP_INSTR;
      id_valid_d = 1'b0;
    end

    case (state_q)
      FETCH: begin
        if (take_redirect) begin
          if (target_misaligned) begin
            state_d = TRAP;
            mis_d   = 1'b1;
          end else begin
            pc_d        = target;
            kill_addr_d = pc_q;
            if (!imem.imem_ready_i) state_d = KILL;
          end
        end else if (imem.imem_ready_i) begin
          pc_d = pc_q + 32'd4;
          if (stall_i) begin
            hold_instr_d = imem.imem_rdata_i;
            hold_pc_d    = pc_q;
            state_d      = HOLD;
          end else begin
            instr_d    = imem.imem_rdata_i;
            id_pc_d    = pc_q;
            id_valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (take_redirect) begin
          if (target_misaligned) begin
            state_d = TRAP;
            mis_d   = 1'b1;
          end else begin
            pc_d    = target;
            state_d = FETCH;
          end
        end else if (!stall_i) begin
          instr_d    = hold_instr_q;
          id_pc_d    = hold_pc_q;
          id_valid_d = 1'b1;
          state_d    = FETCH;
        end
      end
      KILL: begin
        if (imem.imem_ready_i) state_d = FETCH;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      kill_addr_q  <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      instr_q      <= NOP_INSTR;
      id_pc_q      <= '0;
      id_valid_q   <= 1'b0;
      mis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_addr_q  <= kill_addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      instr_q      <= instr_d;
      id_pc_q      <= id_pc_d;
      id_valid_q   <= id_valid_d;
      mis_q        <= mis_d;
    end
  end

  // KILL keeps presenting the abandoned address while pc_q already holds the target.
  assign imem.imem_req_o  = !reset && ((state_q == FETCH) || (state_q == KILL));
  assign imem.imem_addr_o = (state_q == KILL) ? kill_addr_q : pc_q;

  assign instr_o      = instr_q;
  assign op_o         = instr_q[6:0];
  assign id_pc_o      = id_pc_q;
  assign id_pc4_o     = id_pc_q + 32'd4;
  assign id_valid_o   = id_valid_q;
  assign misaligned_o = mis_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios with literal expectations, then random
// stall/redirect/latency traffic checked against an in-order instruction-stream model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic        jalr;
  logic [31:0] rs1;
  logic [31:0] imm;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        mis;

  instruction_fetch_unit_if imem_if();

  instruction_fetch_unit #(
    .RESET_PC  (RST_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem         (imem_if.master),
    .stall_i      (stall),
    .redirect_i   (redirect),
    .jalr_i       (jalr),
    .rs1_i        (rs1),
    .imm_i        (imm),
    .instr_o      (instr),
    .op_o         (op),
    .id_pc_o      (id_pc),
    .id_pc4_o     (id_pc4),
    .id_valid_o   (id_valid),
    .misaligned_o (mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: what ID must hold and which PC comes next in program order
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] exp_next;
  logic        trapped;
  int          idle;

  // memory model state
  logic        pending;
  int unsigned lat;
  logic [31:0] paddr;
  logic        mem_rand;
  int unsigned mem_lat;

  // inputs/outputs captured just before each rising edge
  logic        p_reset, p_stall, p_redir, p_req;
  logic [31:0] p_tgt, p_addr;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h0019_660D) ^ 32'hA5C3_0F00 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, expv, $time);
    end
  endtask

  task automatic mem_drive();
    if (reset || !imem_if.imem_req_o) begin
      imem_if.imem_ready_i = 1'b0;
      pending = 1'b0;
    end else begin
      if (!pending) begin
        pending = 1'b1;
        paddr   = imem_if.imem_addr_o;
        lat     = mem_rand ? $urandom_range(0, 3) : mem_lat;
      end else begin
        chk("addr_stable", imem_if.imem_addr_o, paddr);
      end
      if (lat == 0) begin
        imem_if.imem_ready_i = 1'b1;
        imem_if.imem_rdata_i = memword(imem_if.imem_addr_o);
        pending = 1'b0;
      end else begin
        imem_if.imem_ready_i = 1'b0;
        imem_if.imem_rdata_i = $urandom;
        lat--;
      end
    end
  endtask

  task automatic model_check();
    logic [31:0] s;
    if (p_reset) begin
      m_valid  = 1'b0;
      m_pc     = '0;
      exp_next = RST_PC;
      trapped  = 1'b0;
      idle     = 0;
      chk("rst_valid", id_valid, 0);
      chk("rst_instr", instr, NOP);
      chk("rst_id_pc", id_pc, 0);
      chk("rst_mis", mis, 0);
      chk("rst_req", imem_if.imem_req_o, 0);
    end else if (p_stall) begin
      chk("stall_valid", id_valid, m_valid);
      if (m_valid) begin
        chk("stall_instr", instr, memword(m_pc));
        chk("stall_id_pc", id_pc, m_pc);
      end
    end else if (m_valid && p_redir) begin
      if (p_tgt[1:0] != 2'b00) trapped = 1'b1;
      else exp_next = p_tgt;
      m_valid = 1'b0;
      chk("flush_valid", id_valid, 0);
    end else begin
      if (id_valid) begin
        chk("trap_no_issue", trapped, 0);
        chk("stream_instr", instr, memword(exp_next));
        chk("stream_pc", id_pc, exp_next);
        m_pc     = exp_next;
        exp_next = exp_next + 32'd4;
        m_valid  = 1'b1;
        idle     = 0;
      end else begin
        m_valid = 1'b0;
        if (!trapped) idle++;
        if (idle > 40) begin
          total++;
          bad++;
          $display("FAIL progress no instruction for %0d cycles t=%0t", idle, $time);
          idle = 0;
        end
      end
    end
    if (!p_reset) chk("mis_flag", mis, trapped);
    if (trapped) chk("trap_req", imem_if.imem_req_o, 0);
    if (m_valid) begin
      s = memword(m_pc);
      chk("op", op, s[6:0]);
      chk("pc4", id_pc4, m_pc + 32'd4);
    end else begin
      chk("bubble_instr", instr, NOP);
      chk("bubble_op", op, 7'h13);
    end
  endtask

  task automatic tick();
    #1;
    mem_drive();
    p_reset = reset;
    p_stall = stall;
    p_redir = redirect;
    p_req   = imem_if.imem_req_o;
    p_addr  = imem_if.imem_addr_o;
    p_tgt   = jalr ? ((rs1 + imm) & ~32'd1) : (m_pc + imm);
    @(posedge clk);
    #1;
    model_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; jalr = 1'b0; rs1 = '0; imm = '0;
    imem_if.imem_ready_i = 1'b0; imem_if.imem_rdata_i = '0;
    m_valid = 1'b0; m_pc = '0; exp_next = RST_PC; trapped = 1'b0; idle = 0;
    pending = 1'b0; lat = 0; paddr = '0; mem_rand = 1'b0; mem_lat = 0;

    // zero-wait fetch after reset
    tick(); tick();
    chk("t1_rst_id_pc", id_pc, 32'h0);
    chk("t1_rst_instr", instr, 32'h0000_0013);
    reset = 1'b0;
    tick();
    chk("t1_first_addr", p_addr, 32'h0040_0000);
    chk("t1_first_req", p_req, 1);
    chk("t1_valid", id_valid, 1);
    chk("t1_id_pc", id_pc, 32'h0040_0000);
    chk("t1_next_addr", imem_if.imem_addr_o, 32'h0040_0004);

    // stall on the response of 0x00400004
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold_req", imem_if.imem_req_o, 0);
      chk("t2_hold_id_pc", id_pc, 32'h0040_0000);
    end
    stall = 1'b0;
    tick();
    chk("t2_release_pc", id_pc, 32'h0040_0004);
    chk("t2_release_addr", imem_if.imem_addr_o, 32'h0040_0008);
    tick();
    chk("t2_after_pc", id_pc, 32'h0040_0008);
    tick(); tick();
    chk("t3_branch_pc", id_pc, 32'h0040_0010);

    // backward branch, zero-wait
    redirect = 1'b1; jalr = 1'b0; imm = 32'hFFFF_FFF8;
    tick();
    chk("t3_bubble_valid", id_valid, 0);
    chk("t3_bubble_instr", instr, 32'h0000_0013);
    chk("t3_target_addr", imem_if.imem_addr_o, 32'h0040_0008);
    redirect = 1'b0;
    tick();
    chk("t3_target_pc", id_pc, 32'h0040_0008);

    // redirect while the request is still waiting
    mem_lat = 3; redirect = 1'b1; imm = 32'h20;
    tick();
    chk("t4_kill_addr0", imem_if.imem_addr_o, 32'h0040_000C);
    chk("t4_kill_req", imem_if.imem_req_o, 1);
    redirect = 1'b0;
    tick();
    chk("t4_kill_addr1", imem_if.imem_addr_o, 32'h0040_000C);
    tick();
    chk("t4_kill_addr2", imem_if.imem_addr_o, 32'h0040_000C);
    tick();
    chk("t4_after_kill_addr", imem_if.imem_addr_o, 32'h0040_0028);
    chk("t4_after_kill_valid", id_valid, 0);
    mem_lat = 0;
    tick();
    chk("t4_target_pc", id_pc, 32'h0040_0028);

    // JALR, wrap-around, misaligned trap
    redirect = 1'b1; jalr = 1'b1; rs1 = 32'h0040_0101; imm = 32'd4;
    tick();
    chk("t5_jalr_addr", imem_if.imem_addr_o, 32'h0040_0104);
    redirect = 1'b0;
    tick();
    chk("t5_jalr_pc", id_pc, 32'h0040_0104);
    redirect = 1'b1; rs1 = 32'hFFFF_FFF8; imm = 32'd4;
    tick();
    chk("t5_wrap_addr", imem_if.imem_addr_o, 32'hFFFF_FFFC);
    redirect = 1'b0;
    tick();
    chk("t5_wrap_pc", id_pc, 32'hFFFF_FFFC);
    chk("t5_wrap_pc4", id_pc4, 32'h0);
    chk("t5_wrap_next", imem_if.imem_addr_o, 32'h0);
    tick();
    chk("t5_zero_pc", id_pc, 32'h0);
    redirect = 1'b1; rs1 = 32'h0040_0002; imm = 32'd0;
    tick();
    chk("t5_mis", mis, 1);
    chk("t5_mis_req", imem_if.imem_req_o, 0);
    redirect = 1'b0; jalr = 1'b0;
    tick(); tick(); tick();
    chk("t5_mis_sticky", mis, 1);

    // reset from TRAP, from HOLD and from KILL
    reset = 1'b1;
    tick();
    chk("t6_trap_rst_mis", mis, 0);
    reset = 1'b0;
    tick();
    chk("t6_restart_addr", p_addr, 32'h0040_0000);
    stall = 1'b1;
    tick();
    chk("t6_in_hold", imem_if.imem_req_o, 0);
    reset = 1'b1;
    tick();
    chk("t6_hold_rst_valid", id_valid, 0);
    chk("t6_hold_rst_instr", instr, 32'h0000_0013);
    reset = 1'b0; stall = 1'b0;
    tick();
    chk("t6_hold_restart", p_addr, 32'h0040_0000);
    mem_lat = 3; redirect = 1'b1; imm = 32'h40;
    tick();
    chk("t6_in_kill", imem_if.imem_addr_o, 32'h0040_0004);
    redirect = 1'b0; reset = 1'b1;
    tick();
    chk("t6_kill_rst_valid", id_valid, 0);
    chk("t6_kill_rst_mis", mis, 0);
    reset = 1'b0; mem_lat = 0;
    tick();
    chk("t6_kill_restart", p_addr, 32'h0040_0000);
    chk("t6_kill_restart_pc", id_pc, 32'h0040_0000);

    // random traffic against the stream model
    mem_rand = 1'b1;
    for (int unsigned i = 0; i < 3000; i++) begin
      reset    = trapped ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 299) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 6) == 0);
      jalr     = ($urandom_range(0, 2) == 0);
      rs1      = RST_PC + ($urandom_range(0, 1023) << 2) + $urandom_range(0, 1);
      imm      = ($urandom_range(0, 255) << 2) - 32'd512;
      if ($urandom_range(0, 39) == 0) imm = imm + 32'd2;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage feeding the decode/immediate-generation logic. It holds the PC, issues one-outstanding requests to instruction memory, buffers the returned word, and presents it as a registered IF/ID instruction plus opcode. It also consumes the decoded immediate to compute branch/JAL/JALR redirect targets.

Parameters:
RESET_PC, 32'h0040_0000, PC loaded on reset.
NOP_INSTR, 32'h0000_0013, instruction presented on instr_o when no valid instruction is in ID (addi x0,x0,0).

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
imem_req_o  output  1  fetch request to instruction memory.
imem_addr_o  output  32  fetch address (current PC).
imem_ready_i  input  1  memory response strobe; data valid this cycle.
imem_rdata_i  input  32  fetched instruction word.
stall_i  input  1  downstream cannot accept; ID register holds.
redirect_i  input  1  taken branch/JAL/JALR for the instruction in ID.
jalr_i  input  1  redirect target is register-relative (JALR).
rs1_i  input  32  rs1 value for JALR.
imm_i  input  32  sign-extended immediate of the instruction in ID.
instr_o  output  32  IF/ID instruction word.
op_o  output  7  instr_o[6:0].
id_pc_o  output  32  PC of instr_o.
id_pc4_o  output  32  id_pc_o + 4 (link value), modulo 2^32.
id_valid_o  output  1  instr_o is a real instruction.
misaligned_o  output  1  sticky fetch-target misalignment flag.

Behaviour:
- Reset (sampled at a rising edge): pc=RESET_PC, state=FETCH, hold buffer empty, id_valid_o=0, instr_o=NOP_INSTR, id_pc_o=0, misaligned_o=0. imem_req_o=0 while reset is high.
- States: FETCH, HOLD, KILL, TRAP.
- imem_req_o=1 in FETCH and KILL, 0 in HOLD and TRAP. imem_addr_o=pc, stable while the request is pending.
- Memory protocol: one outstanding request. imem_ready_i may assert in the same cycle as the request (zero-wait) or any later cycle. It is a one-cycle strobe.
- Target: jalr_i=1 -> (rs1_i+imm_i) & ~1. Otherwise id_pc_o+imm_i. 32-bit wrap-around.
- redirect_i is honoured only when id_valid_o=1 and stall_i=0. Otherwise it is ignored.
- Redirect handling: if target[1:0]!=0, go to TRAP and set misaligned_o. Otherwise pc<=target, ID flushed next edge (id_valid_o=0, instr_o=NOP_INSTR).
  - FETCH with imem_ready_i=1 in the same cycle: the returned word is discarded; stay FETCH.
  - FETCH with imem_ready_i=0: go to KILL.
  - HOLD: the buffer is discarded; go to FETCH.
- FETCH, no redirect:
  - imem_ready_i=1 and stall_i=0: ID<=(rdata, pc, valid=1); pc<=pc+4.
  - imem_ready_i=1 and stall_i=1: word stored in hold buffer (with its pc); pc<=pc+4; go to HOLD.
  - imem_ready_i=0 and stall_i=0: ID becomes bubble.
- HOLD: ID holds while stall_i=1. On stall_i=0, the buffer moves into ID with valid=1; go to FETCH.
- KILL: keep the request at the old address until imem_ready_i. Drop that data, go to FETCH (pc already holds target). ID shows a bubble meanwhile.
- TRAP: no requests; ID bubble; misaligned_o=1 until reset.
- stall_i=1 in any state: ID register unchanged.
- Latency: zero-wait memory and no stall gives instruction at PC on instr_o one cycle after it is addressed. Throughput is 1 instr/cycle.
- Redirect penalty: one bubble cycle (zero-wait). No instruction is lost or duplicated across stalls.
- pc+4 at 32'hFFFF_FFFC wraps to 0.
- Reset mid-operation (any state) returns to reset values. Memory must abort any in-flight request on the same reset.

Test Plan:
1. Reset, then zero-wait memory returning addr-dependent words -> addresses 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; instr_o follows one cycle later; id_valid_o=1; op_o=instr_o[6:0].
2. Response at 0x00400004 arrives with stall_i=1 for 3 cycles -> HOLD, imem_req_o=0, ID unchanged. On release, word of 0x00400004 appears once, followed by 0x00400008.
3. Branch at id_pc 0x00400010 with redirect_i=1 and imm_i=0xFFFFFFF8 -> next address 0x00400008. One bubble (id_valid_o=0, instr_o=0x00000013); the same-cycle response is discarded.
4. Redirect while ready is low for 3 cycles -> KILL; address held at old PC until ready; data dropped; next request at target. No stale word reaches ID.
5. JALR with rs1=0x00400101, imm=4 -> target 0x00400104. JALR with rs1=0x00400002, imm=0 -> misaligned_o=1, imem_req_o=0 until reset.
6. Reset asserted while in HOLD and in KILL -> next cycle id_valid_o=0, instr_o=NOP_INSTR, misaligned_o=0. First request after deassertion is at 0x00400000.
